// File: rtl/alu_pin_driver.sv
// alu_pin_driver: host-side sequencer for the tt_um_reg ALU/register tile pins.
// Takes one {op, a, b} command, plays it onto ui_in/uio_in as LOAD_A, LOAD_B,
// EXEC, waits for the tile to settle, samples uo_out and returns it.
// Optional build macro ALU_DRV_CHECK_EN adds a reference ALU model, a live
// rsp_err flag and a saturating err_cnt port.
// The pin outputs are registered, so the tile sees each phase one cycle after
// the FSM enters it; WAIT therefore spends one extra cycle letting the pins
// drop to idle before counting RESP_LAT settle cycles.
module alu_pin_driver #(
  parameter int RESP_LAT = 2,
  parameter int HOLD_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] pin_ui,
  output logic [7:0] pin_uio,
  input  logic [7:0] pin_uo,
  output logic       busy
`ifdef ALU_DRV_CHECK_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    WAIT   = 3'd4,
    RESP   = 3'd5
  } state_t;

  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYC - 1);
  localparam logic [3:0] LAT_LD  = 4'(RESP_LAT);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       accept;
  logic       sample;
  logic [2:0] op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;

`ifdef ALU_DRV_CHECK_EN
  logic [7:0] expected;
  logic       mismatch;
  logic       rsp_err_q;

  function automatic logic [7:0] alu_ref(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return ~a;
      3'b110:  return a << b[2:0];
      default: return a >> b[2:0];
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  // Next-state, counter reload and handshake decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != 4'd0) ? cnt - 4'd1 : cnt;
    accept    = 1'b0;
    sample    = 1'b0;
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = LOAD_A;
          cnt_nxt   = HOLD_LD;
        end
      end
      LOAD_A: begin
        if (cnt == 4'd0) begin
          state_nxt = LOAD_B;
          cnt_nxt   = HOLD_LD;
        end
      end
      LOAD_B: begin
        if (cnt == 4'd0) begin
          state_nxt = EXEC;
          cnt_nxt   = HOLD_LD;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          state_nxt = WAIT;
          cnt_nxt   = LAT_LD;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          sample    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and phase counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Command latch; only meaningful once a command has been accepted
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= cmd_op;
      a_q  <= cmd_a;
      b_q  <= cmd_b;
    end
  end

  // Registered pin drive derived from the current phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pin_ui  <= 8'h00;
      pin_uio <= 8'h00;
    end else begin
      case (state)
        LOAD_A: begin
          pin_ui  <= a_q;
          pin_uio <= {3'b000, 2'b01, op_q};
        end
        LOAD_B: begin
          pin_ui  <= b_q;
          pin_uio <= {3'b000, 2'b10, op_q};
        end
        EXEC: begin
          pin_ui  <= 8'h00;
          pin_uio <= {3'b000, 2'b11, op_q};
        end
        default: begin
          pin_ui  <= 8'h00;
          pin_uio <= 8'h00;
        end
      endcase
    end
  end

  // Capture of the tile result at the end of the settle window
  always_ff @(posedge clk) begin
    if (!rst_n) rsp_data <= 8'h00;
    else if (sample) rsp_data <= pin_uo;
  end

`ifdef ALU_DRV_CHECK_EN
  assign expected = alu_ref(op_q, a_q, b_q);
  assign mismatch = (pin_uo != expected);
  assign rsp_err  = rsp_err_q;

  // Mismatch flag and sticky saturating error count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
      err_cnt   <= 8'h00;
    end else if (sample) begin
      rsp_err_q <= mismatch;
      if (mismatch) err_cnt <= sat_inc(err_cnt);
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pin_driver.sv
// tb_alu_pin_driver: directed bench for alu_pin_driver with a small tile model
// and a scoreboard queue checked by an independent response monitor.
module tb_alu_pin_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [7:0] pin_ui;
  logic [7:0] pin_uio;
  logic [7:0] pin_uo;
  logic       busy;
`ifdef ALU_DRV_CHECK_EN
  logic [7:0] err_cnt;
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_pin_driver dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .pin_ui(pin_ui), .pin_uio(pin_uio), .pin_uo(pin_uo),
    .busy(busy)
`ifdef ALU_DRV_CHECK_EN
    , .err_cnt(err_cnt)
`endif
  );

  // Tile model: latches operands per phase and computes on the execute phase
  logic [7:0] t_a = 8'h00, t_b = 8'h00, t_res = 8'h00;
  logic       force_en;
  logic [7:0] force_val;

  function automatic logic [7:0] tile_alu(input logic [2:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return ~a;
      3'b110:  return a << b[2:0];
      default: return a >> b[2:0];
    endcase
  endfunction

  always @(posedge clk) begin
    case (pin_uio[4:3])
      2'b01:   t_a <= pin_ui;
      2'b10:   t_b <= pin_ui;
      2'b11:   t_res <= tile_alu(pin_uio[2:0], t_a, t_b);
      default: ;
    endcase
  end

  assign pin_uo = force_en ? force_val : t_res;

  // Scoreboard
  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Response monitor: a handshake completes at the next posedge
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got data 0x%0h with no pending command", rsp_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_err", rsp_err, e.err);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic ee, input bit push);
    int k;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    if (k == 50) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: cmd_ready never rose");
    end else if (push) begin
      sb.push_back('{data: ed, err: ee});
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) break;
    end
    if (k == 100) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_timeout: %0d responses still pending", sb.size());
    end
    @(posedge clk); #1;
  endtask

  logic [2:0] t_op [5] = '{3'b101, 3'b110, 3'b111, 3'b001, 3'b011};
  logic [7:0] t_av [5] = '{8'h5A, 8'h81, 8'h81, 8'h10, 8'h0C};
  logic [7:0] t_bv [5] = '{8'h00, 8'h0B, 8'h02, 8'h03, 8'h30};
  logic [7:0] t_ex [5] = '{8'hA5, 8'h08, 8'h20, 8'h0D, 8'h3C};
  logic [7:0] uio_seq [5] = '{8'h00, 8'h08, 8'h10, 8'h18, 8'h00};
  logic [7:0] ui_seq  [5] = '{8'h00, 8'h1F, 8'h01, 8'h00, 8'h00};

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k;
    logic [7:0] held;
    bit seen;
`ifdef ALU_DRV_CHECK_EN
    logic [7:0] cnt_before;
`endif
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 8'h00; cmd_b = 8'h00;
    rsp_ready = 1'b1; force_en = 1'b0; force_val = 8'h00;

    // 1. reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_pin_ui", pin_ui, 8'h00);
    check("rst_pin_uio", pin_uio, 8'h00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_rsp_err", rsp_err, 1'b0);
`ifdef ALU_DRV_CHECK_EN
    check("rst_err_cnt", err_cnt, 8'h00);
`endif
    @(posedge clk); #1;

    // 2. ADD with pin sequence and latency
    issue(3'b000, 8'h1F, 8'h01, 8'h20, 1'b0, 1'b1);
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("add_busy", busy, 1'b1);
        check("add_cmd_ready", cmd_ready, 1'b0);
      end
      if (k <= 4) begin
        check($sformatf("add_uio_%0d", k), pin_uio, uio_seq[k]);
        check($sformatf("add_ui_%0d", k), pin_ui, ui_seq[k]);
      end
      if (rsp_valid) break;
    end
    check("add_latency", k, 6);
    wait_done();

    // 3. wrap-around add
    issue(3'b000, 8'hFF, 8'h02, 8'h01, 1'b0, 1'b1);
    wait_done();

    // 4. forced mismatch on AND
`ifdef ALU_DRV_CHECK_EN
    cnt_before = err_cnt;
`endif
    force_en = 1'b1; force_val = 8'h31;
    issue(3'b010, 8'hF0, 8'h3C, 8'h31, CHK, 1'b1);
    wait_done();
    force_en = 1'b0;
`ifdef ALU_DRV_CHECK_EN
    check("err_cnt_inc", err_cnt, cnt_before + 8'd1);
`endif

    // remaining opcodes
    for (int i = 0; i < 5; i++) begin
      issue(t_op[i], t_av[i], t_bv[i], t_ex[i], 1'b0, 1'b1);
      wait_done();
    end

    // 5. backpressure with a second command held pending
    rsp_ready = 1'b0;
    issue(3'b100, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b1);
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    check("bp_rsp_seen", k < 30, 1'b1);
    held = rsp_data;
    cmd_op = 3'b001; cmd_a = 8'h10; cmd_b = 8'h03; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_cmd_ready", cmd_ready, 1'b0);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_stable", rsp_data, held);
      check("bp_pin_uio", pin_uio, 8'h00);
    end
    sb.push_back('{data: 8'h0D, err: 1'b0});
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk); #1;
    check("bp_no_accept_before_hs", cmd_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_after_hs", busy, 1'b0);
    check("bp_rsp_drop", rsp_valid, 1'b0);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_second_accepted", busy, 1'b1);
    wait_done();

    // 6. reset during LOAD_B abandons the command
    issue(3'b011, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_pin_ui", pin_ui, 8'h00);
    check("mid_rst_pin_uio", pin_uio, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("mid_rst_no_rsp", seen, 1'b0);
    check("mid_rst_cmd_ready", cmd_ready, 1'b1);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
